quad_decoder: RTL

- Quadrature-encoder front end that sits directly upstream of the team's 4-bit up/down counter.
- Synchronises and glitch-filters raw encoder channels A/B and decodes Gray-code transitions.
- Drives a one-cycle count-enable pulse plus the UP_DOWN direction line the counter consumes.
- Flags illegal transitions (both channels changing at once) with a sticky error.

---
 rtl/quad_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature-encoder front end: synchronises and glitch-filters channels A/B,
// decodes Gray-code quarter-steps into a one-cycle count enable plus direction
// for the downstream up/down counter, and flags illegal double-bit jumps.
module quad_decoder #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic C,
   input  logic CLR_N,
   input  logic A,
   input  logic B,
   input  logic EN,
   input  logic ERR_CLR,
   output logic CNT_EN,
   output logic UP_DOWN,
   output logic ERR,
   output logic RDY
);

   typedef enum logic {SEED, RUN} state_t;

   localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
   // seed count spans FILT_LEN+2 cycles, so it needs one bit beyond 4 for FILT_LEN=15
   localparam logic [4:0] SEED_INIT = 5'(FILT_LEN + 1);

   state_t      state;
   logic [1:0]  sync_a;    // [0] = s1, [1] = s2
   logic [1:0]  sync_b;
   logic [3:0]  fcnt_a;
   logic [3:0]  fcnt_b;
   logic        filt_a;
   logic        filt_b;
   logic [1:0]  prev;
   logic [4:0]  seed_cnt;

   logic [1:0]  cur;
   logic        moved;
   logic        illegal;
   logic        dir_up;

   // two-flop synchronisers for the asynchronous encoder channels
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], A};
         sync_b <= {sync_b[0], B};
      end
   end

   // per-channel stability filter; seeded straight from s2 while in SEED
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         fcnt_a <= '0;
         fcnt_b <= '0;
         filt_a <= 1'b0;
         filt_b <= 1'b0;
      end else if (state == SEED) begin
         fcnt_a <= '0;
         fcnt_b <= '0;
         filt_a <= sync_a[1];
         filt_b <= sync_b[1];
      end else begin
         if (sync_a[1] == filt_a) begin
            fcnt_a <= '0;
         end else if (fcnt_a == FILT_LAST) begin
            filt_a <= sync_a[1];
            fcnt_a <= '0;
         end else begin
            fcnt_a <= fcnt_a + 4'd1;
         end

         if (sync_b[1] == filt_b) begin
            fcnt_b <= '0;
         end else if (fcnt_b == FILT_LAST) begin
            filt_b <= sync_b[1];
            fcnt_b <= '0;
         end else begin
            fcnt_b <= fcnt_b + 4'd1;
         end
      end
   end

   // classify the filtered transition: none, legal quarter-step, or double jump
   always_comb begin
      cur     = {filt_a, filt_b};
      moved   = (cur != prev);
      illegal = &(cur ^ prev);
      // up order 00->01->11->10->00 reduces to prev[1] xor cur[0]
      dir_up  = prev[1] ^ cur[0];
   end

   // SEED/RUN sequencing with registered count enable, direction, error and ready
   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         state    <= SEED;
         seed_cnt <= SEED_INIT;
         prev     <= '0;
         CNT_EN   <= 1'b0;
         UP_DOWN  <= 1'b1;
         ERR      <= 1'b0;
         RDY      <= 1'b0;
      end else begin
         prev <= cur;
         case (state)
            SEED: begin
               CNT_EN <= 1'b0;
               if (seed_cnt == '0) begin
                  state <= RUN;
                  RDY   <= 1'b1;
               end else begin
                  seed_cnt <= seed_cnt - 5'd1;
               end
            end
            RUN: begin
               CNT_EN <= EN && moved && !illegal;
               if (EN && moved && !illegal) begin
                  UP_DOWN <= dir_up;
               end
               if (EN && illegal) begin
                  ERR <= 1'b1;
               end else if (ERR_CLR) begin
                  ERR <= 1'b0;
               end
            end
            default: state <= SEED;
         endcase
      end
   end

endmodule
